// File: rtl/ef_i2s_pkg.sv
// Constants and helpers for the I2S transmit path. The prescaler, event and slot
// definitions here are also used by the receive path.
package ef_i2s_pkg;

  localparam int SLOT_BITS = 32;
  localparam int PRESC_W   = 8;
  localparam int CTR_W     = 5;
  localparam int SIZE_W    = 6;

  localparam logic [1:0] CH_LEFT  = 2'b10;
  localparam logic [1:0] CH_RIGHT = 2'b01;
  localparam logic       WS_LEFT  = 1'b0;

  // A sample size of 0, or one larger than the slot, means a full 32-bit sample.
  function automatic logic [SIZE_W-1:0] eff_size(input logic [SIZE_W-1:0] size);
    return (size == '0 || size > SIZE_W'(SLOT_BITS)) ? SIZE_W'(SLOT_BITS) : size;
  endfunction

  // Left shift that moves a right-aligned sample up to the slot MSB.
  function automatic logic [SIZE_W-1:0] load_shift(input logic [SIZE_W-1:0] size);
    return SIZE_W'(SLOT_BITS) - eff_size(size);
  endfunction

endpackage

// File: rtl/ef_i2s_tx_fifo.sv
// Synchronous FIFO for the I2S transmitter: registered pointers, registered
// full/empty flags and an AW+1-bit fill level. Read data is first-word fall-through.
module i2s_tx_fifo #(
  parameter int DW = 32,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          rd,
  input  logic          wr,
  input  logic [DW-1:0] w_data,
  output logic [DW-1:0] r_data,
  output logic          empty,
  output logic          full,
  output logic [AW:0]   level
);

  localparam int DEPTH = 2**AW;

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   level_q, level_d;
  logic          empty_q, full_q;
  logic          do_wr, do_rd;

  assign do_wr = wr & ~full_q;
  assign do_rd = rd & ~empty_q;

  // NOTE: a default assignment first keeps always_comb from inferring a latch.
  always_comb begin
    level_d = level_q;
    if (do_wr && !do_rd)      level_d = level_q + (AW+1)'(1);
    else if (do_rd && !do_wr) level_d = level_q - (AW+1)'(1);
  end

  // NOTE: the storage array is not reset; only pointers and flags define its contents.
  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= w_data;
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_rd) rd_ptr_q <= rd_ptr_q + AW'(1);
      level_q <= level_d;
      empty_q <= (level_d == '0);
      full_q  <= (level_d == (AW+1)'(DEPTH));
    end
  end

  assign r_data = mem_q[rd_ptr_q];
  assign empty  = empty_q;
  assign full   = full_q;
  assign level  = level_q;

endmodule

// File: rtl/ef_i2s_tx.sv
// I2S transmit master: generates SCK/WS from a prescaler and shifts FIFO samples
// out MSB-first on SDO in Philips or left-justified framing, 32-bit slots.
module ef_i2s_tx
  import ef_i2s_pkg::*;
#(
  parameter int DW = 32,
  parameter int AW = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [PRESC_W-1:0] sck_prescaler,
  input  logic [SIZE_W-1:0]  sample_size,
  input  logic               left_justified,
  input  logic [1:0]         channels,
  input  logic               fifo_wr,
  input  logic [DW-1:0]      fifo_wdata,
  input  logic [AW:0]        fifo_level_threshold,
  output logic               fifo_full,
  output logic               fifo_empty,
  output logic [AW:0]        fifo_level,
  output logic               fifo_level_below,
  output logic               overflow,
  output logic               underflow,
  output logic               sck,
  output logic               ws,
  output logic               sdo
);

  logic [PRESC_W-1:0]   presc_q, presc_d;
  logic [CTR_W-1:0]     bit_ctr_q, bit_ctr_d;
  logic [SLOT_BITS-1:0] sr_q, sr_d, sr_load, word;
  logic                 sck_q, sck_d, ws_q, ws_d;
  logic                 d_q, d_d, sdo_q, sdo_d, lj_q, lj_d;
  logic                 overflow_q, underflow_q, underflow_d;
  logic                 tick, fall_ev, slot_ev, slot_ws, ch_en, pop;
  logic [DW-1:0]        fifo_rdata;

  i2s_tx_fifo #(.DW(DW), .AW(AW)) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .rd     (pop),
    .wr     (fifo_wr),
    .w_data (fifo_wdata),
    .r_data (fifo_rdata),
    .empty  (fifo_empty),
    .full   (fifo_full),
    .level  (fifo_level)
  );

  assign tick    = en && (presc_q == '0);
  assign fall_ev = tick && sck_q;
  assign slot_ev = fall_ev && (bit_ctr_q == CTR_W'(SLOT_BITS-1));

  // The slot being started takes the new WS value; it decides which channel bit applies.
  assign slot_ws = ~ws_q;
  assign ch_en   = (slot_ws == WS_LEFT) ? |(channels & CH_LEFT) : |(channels & CH_RIGHT);

  // An empty FIFO is judged on the registered flag, so a same-cycle write is not popped.
  assign pop         = slot_ev && ch_en && !fifo_empty;
  assign underflow_d = slot_ev && ch_en && fifo_empty;

  assign word    = SLOT_BITS'(fifo_rdata);
  assign sr_load = word << load_shift(sample_size);

  always_comb begin
    presc_d   = presc_q;
    sck_d     = sck_q;
    ws_d      = ws_q;
    bit_ctr_d = bit_ctr_q;
    sr_d      = sr_q;
    d_d       = d_q;
    lj_d      = lj_q;
    sdo_d     = sdo_q;
    if (en) presc_d = (presc_q == '0) ? sck_prescaler : presc_q - PRESC_W'(1);
    if (tick) sck_d = ~sck_q;
    if (slot_ev) begin
      ws_d = slot_ws;
      lj_d = left_justified;
    end
    if (fall_ev) begin
      bit_ctr_d = bit_ctr_q + CTR_W'(1);
      d_d       = sr_q[SLOT_BITS-1];
      if (slot_ev) sr_d = pop ? sr_load : '0;
      else         sr_d = {sr_q[SLOT_BITS-2:0], 1'b0};
      // Left-justified drives the freshly loaded/shifted MSB; Philips lags one SCK via d.
      sdo_d = lj_d ? sr_d[SLOT_BITS-1] : d_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q     <= '0;
      sck_q       <= 1'b0;
      ws_q        <= 1'b1;
      bit_ctr_q   <= '0;
      sr_q        <= '0;
      d_q         <= 1'b0;
      lj_q        <= 1'b0;
      sdo_q       <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      presc_q     <= presc_d;
      sck_q       <= sck_d;
      ws_q        <= ws_d;
      bit_ctr_q   <= bit_ctr_d;
      sr_q        <= sr_d;
      d_q         <= d_d;
      lj_q        <= lj_d;
      sdo_q       <= sdo_d;
      overflow_q  <= fifo_wr && fifo_full;
      underflow_q <= underflow_d;
    end
  end

  assign fifo_level_below = (fifo_level < fifo_level_threshold);
  assign overflow         = overflow_q;
  assign underflow        = underflow_q;
  assign sck              = sck_q;
  assign ws               = ws_q;
  assign sdo              = sdo_q;

endmodule

// File: tb/tb_ef_i2s_tx.sv
// Directed bench for ef_i2s_tx: reset, Philips/left-justified framing, channel
// masking, underflow/overflow, prescaler timing, enable freeze and level threshold.
module tb_ef_i2s_tx;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [7:0]  sck_prescaler = 8'd0;
  logic [5:0]  sample_size = 6'd16;
  logic        left_justified = 1'b0;
  logic [1:0]  channels = 2'b11;
  logic        fifo_wr = 1'b0;
  logic [31:0] fifo_wdata = 32'd0;
  logic [4:0]  fifo_level_threshold = 5'd0;
  logic        fifo_full, fifo_empty, fifo_level_below, overflow, underflow;
  logic [4:0]  fifo_level;
  logic        sck, ws, sdo;

  int errors = 0;
  int checks = 0;
  int cur_edge = -1;
  int half = 1;
  logic [31:0] v;
  logic [31:0] expv;

  ef_i2s_tx #(.DW(32), .AW(4)) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .en                   (en),
    .sck_prescaler        (sck_prescaler),
    .sample_size          (sample_size),
    .left_justified       (left_justified),
    .channels             (channels),
    .fifo_wr              (fifo_wr),
    .fifo_wdata           (fifo_wdata),
    .fifo_level_threshold (fifo_level_threshold),
    .fifo_full            (fifo_full),
    .fifo_empty           (fifo_empty),
    .fifo_level           (fifo_level),
    .fifo_level_below     (fifo_level_below),
    .overflow             (overflow),
    .underflow            (underflow),
    .sck                  (sck),
    .ws                   (ws),
    .sdo                  (sdo)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock; edges seen with en=1 advance the timing-edge index.
  task automatic step();
    @(posedge clk);
    if (en) cur_edge++;
    #1;
  endtask

  task automatic goto_edge(input int e);
    int guard = 0;
    while (cur_edge < e && guard < 5000) begin
      step();
      guard++;
    end
    if (cur_edge < e) check("edge_budget", 32'(cur_edge), 32'(e));
  endtask

  task automatic do_reset();
    en = 1'b0;
    fifo_wr = 1'b0;
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic write_word(input logic [31:0] data);
    fifo_wdata = data;
    fifo_wr = 1'b1;
    step();
    fifo_wr = 1'b0;
  endtask

  task automatic start();
    cur_edge = -1;
    en = 1'b1;
  endtask

  // Fall event n lands on timing edge (2n-1)*half; gather 32 of them MSB-first.
  task automatic collect(input int first_fall, output logic [31:0] bits);
    bits = '0;
    for (int i = 0; i < 32; i++) begin
      goto_edge((2 * (first_fall + i) - 1) * half);
      bits = {bits[30:0], sdo};
    end
  endtask

  initial begin
    // ---- 1: reset values, then reset mid-slot with words queued
    step();
    step();
    check("rst_sck", sck, 0);
    check("rst_ws", ws, 1);
    check("rst_sdo", sdo, 0);
    check("rst_empty", fifo_empty, 1);
    check("rst_full", fifo_full, 0);
    check("rst_level", fifo_level, 0);
    check("rst_ovf", overflow, 0);
    check("rst_unf", underflow, 0);
    rst_n = 1'b1;
    step();
    half = 1;
    write_word(32'h0000FFFF);
    write_word(32'h0000FFFF);
    write_word(32'h0000FFFF);
    check("t1_level3", fifo_level, 3);
    start();
    goto_edge(70);
    check("t1_pre_sck", sck, 1);
    check("t1_pre_ws", ws, 0);
    check("t1_pre_sdo", sdo, 1);
    check("t1_pre_level", fifo_level, 2);
    rst_n = 1'b0;
    #1;
    check("t1_async_sck", sck, 0);
    check("t1_async_ws", ws, 1);
    check("t1_async_sdo", sdo, 0);
    check("t1_async_level", fifo_level, 0);
    check("t1_async_empty", fifo_empty, 1);

    // ---- 2: Philips, prescaler 0, 16-bit stereo
    do_reset();
    sck_prescaler = 8'd0; sample_size = 6'd16; left_justified = 1'b0; channels = 2'b11;
    write_word(32'h0000A5F0);
    write_word(32'h00001234);
    check("t2_level2", fifo_level, 2);
    start();
    goto_edge(0);
    check("t2_sck_e0", sck, 1);
    goto_edge(1);
    check("t2_sck_e1", sck, 0);
    goto_edge(62);
    check("t2_ws_before", ws, 1);
    check("t2_sdo_before", sdo, 0);
    goto_edge(63);
    check("t2_ws_left", ws, 0);
    check("t2_level1", fifo_level, 1);
    collect(32, v);
    check("t2_left_bits", v, 32'h52F80000);
    goto_edge(126);
    check("t2_ws_still_left", ws, 0);
    collect(64, v);
    check("t2_right_bits", v, 32'h091A0000);
    check("t2_ws_right", ws, 1);
    check("t2_level0", fifo_level, 0);
    goto_edge(190);
    check("t2_unf_quiet", underflow, 0);
    goto_edge(191);
    check("t2_unf_pulse", underflow, 1);
    check("t2_ws_left2", ws, 0);

    // ---- 3: left-justified, 24-bit, upper bits discarded
    do_reset();
    sample_size = 6'd24; left_justified = 1'b1; channels = 2'b11;
    write_word(32'hFFABCDEF);
    start();
    goto_edge(62);
    check("t3_sdo_before", sdo, 0);
    goto_edge(63);
    check("t3_ws_left", ws, 0);
    check("t3_msb_on_ws_edge", sdo, 1);
    collect(32, v);
    check("t3_left_bits", v, 32'hABCDEF00);
    goto_edge(127);
    check("t3_right_unf", underflow, 1);
    check("t3_right_sdo", sdo, 0);

    // ---- 4: left channel only, four 8-bit words
    do_reset();
    sample_size = 6'd8; left_justified = 1'b0; channels = 2'b10;
    write_word(32'h00000081);
    write_word(32'h00000042);
    write_word(32'h000000C3);
    write_word(32'h00000024);
    start();
    collect(32, v);
    check("t4_left0_bits", v, 32'h40800000);
    goto_edge(127);
    check("t4_right_no_unf", underflow, 0);
    check("t4_right_level", fifo_level, 3);
    collect(64, v);
    check("t4_right_bits", v, 32'h00000000);
    collect(96, v);
    check("t4_left1_bits", v, 32'h21000000);
    check("t4_level2", fifo_level, 2);

    // ---- 5a: empty FIFO, stereo: underflow every slot, sdo stays low
    do_reset();
    sample_size = 6'd16; channels = 2'b11;
    start();
    goto_edge(62);
    check("t5_unf_none", underflow, 0);
    goto_edge(63);
    check("t5_unf_left", underflow, 1);
    goto_edge(64);
    check("t5_unf_width", underflow, 0);
    v = '0;
    for (int e = 64; e <= 126; e++) begin
      goto_edge(e);
      v[0] = v[0] | sdo;
    end
    check("t5_sdo_zero", v, 0);
    goto_edge(127);
    check("t5_unf_right", underflow, 1);

    // ---- 5b: overflow on the 17th write; size 0 means 32 bits
    do_reset();
    sample_size = 6'd0; left_justified = 1'b0; channels = 2'b11;
    for (int i = 0; i < 16; i++) write_word(32'hC0000001 + 32'(i));
    check("t5_full", fifo_full, 1);
    check("t5_level16", fifo_level, 16);
    check("t5_no_ovf", overflow, 0);
    write_word(32'hDEADBEEF);
    check("t5_ovf_pulse", overflow, 1);
    check("t5_level_kept", fifo_level, 16);
    step();
    check("t5_ovf_width", overflow, 0);
    start();
    collect(32, v);
    check("t5_left_bits", v, 32'h60000000);
    check("t5_not_full", fifo_full, 0);
    collect(64, v);
    check("t5_right_bits", v, 32'hE0000001);
    check("t5_level14", fifo_level, 14);

    // ---- 6: prescaler 3, enable freeze mid-slot, level threshold
    do_reset();
    half = 4;
    sck_prescaler = 8'd3; sample_size = 6'd16; left_justified = 1'b0; channels = 2'b10;
    fifo_level_threshold = 5'd4;
    write_word(32'h0000C3A5);
    write_word(32'h00000001);
    write_word(32'h00000002);
    check("t6_below_at3", fifo_level_below, 1);
    write_word(32'h00000003);
    check("t6_below_at4", fifo_level_below, 0);
    start();
    goto_edge(0);
    check("t6_sck_e0", sck, 1);
    goto_edge(3);
    check("t6_sck_e3", sck, 1);
    goto_edge(4);
    check("t6_sck_e4", sck, 0);
    goto_edge(8);
    check("t6_sck_e8", sck, 1);
    expv = 32'h61D28000;
    v = '0;
    for (int i = 0; i < 32; i++) begin
      goto_edge((2 * (32 + i) - 1) * half);
      v = {v[30:0], sdo};
      if (i == 0) begin
        check("t6_ws_left", ws, 0);
        check("t6_level3", fifo_level, 3);
        check("t6_below_again", fifo_level_below, 1);
      end
      if (i == 9) begin
        en = 1'b0;
        repeat (10) step();
        check("t6_hold_sck", sck, 0);
        check("t6_hold_ws", ws, 0);
        check("t6_hold_sdo", sdo, expv[31-i]);
        en = 1'b1;
      end
    end
    check("t6_left_bits", v, expv);
    goto_edge((2 * 64 - 1) * half - 1);
    check("t6_ws_pre_right", ws, 0);
    goto_edge((2 * 64 - 1) * half);
    check("t6_ws_right", ws, 1);
    check("t6_right_no_pop", fifo_level, 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
